// File: rtl/tick_gen_pkg.sv
// ============================================================================
// tick_gen_pkg : shared constants for the programmable tick generator
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package tick_gen_pkg;

    localparam int SEL_W = 2;

    localparam logic [0:0] ST_STOP = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam longint unsigned DEF_LIMIT_0 = 64'd8388608;   // 2**23
    localparam longint unsigned DEF_LIMIT_1 = 64'd16777216;  // 2**24
    localparam longint unsigned DEF_LIMIT_2 = 64'd33554432;  // 2**25
    localparam longint unsigned DEF_LIMIT_3 = 64'd67108864;  // 2**26

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// sync_2ff : two-flop synchroniser, parameterised width, async active-low reset
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    always_comb begin
        meta_d = i_d;
        sync_d = meta_q;
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q;

endmodule

`default_nettype wire

// File: rtl/tick_gen.sv
// ============================================================================
// tick_gen : selectable-period single-cycle tick strobe with optional manual
//            single-step while stopped (enabled by macro TICK_GEN_STEP_EN)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int                NB_COUNT = 32,
    parameter logic [NB_COUNT:0] LIMIT_0  = (NB_COUNT+1)'(DEF_LIMIT_0),
    parameter logic [NB_COUNT:0] LIMIT_1  = (NB_COUNT+1)'(DEF_LIMIT_1),
    parameter logic [NB_COUNT:0] LIMIT_2  = (NB_COUNT+1)'(DEF_LIMIT_2),
    parameter logic [NB_COUNT:0] LIMIT_3  = (NB_COUNT+1)'(DEF_LIMIT_3)
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic [SEL_W-1:0] i_sel,
    input  logic             i_step,
    output logic             o_valid,
    output logic             o_running
);

    logic             en_s;
    logic [SEL_W-1:0] sel_s;
    logic [SEL_W-1:0] sel_d, sel_q;
    logic [0:0]       state_d, state_q;
    logic [NB_COUNT-1:0] count_d, count_q;
    logic             valid_d, valid_q;
    logic             running_d, running_q;
    logic [NB_COUNT:0] limit;
    logic [NB_COUNT:0] limit_m1;
    logic             step_fire;

    sync_2ff #(.WIDTH(1)) u_sync_en (
        .clock   (clock),
        .i_reset (i_reset),
        .i_d     (i_enable),
        .o_q     (en_s)
    );

    sync_2ff #(.WIDTH(SEL_W)) u_sync_sel (
        .clock   (clock),
        .i_reset (i_reset),
        .i_d     (i_sel),
        .o_q     (sel_s)
    );

`ifdef TICK_GEN_STEP_EN
    logic step_s;
    logic step_d, step_q;
    logic step_edge_d, step_edge_q;

    sync_2ff #(.WIDTH(1)) u_sync_step (
        .clock   (clock),
        .i_reset (i_reset),
        .i_d     (i_step),
        .o_q     (step_s)
    );

    always_comb begin
        step_d      = step_s;
        step_edge_d = step_s & ~step_q;
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            step_q      <= 1'b0;
            step_edge_q <= 1'b0;
        end else begin
            step_q      <= step_d;
            step_edge_q <= step_edge_d;
        end
    end

    assign step_fire = step_edge_q;
`else
    logic unused_step;
    assign unused_step = i_step;
    assign step_fire   = 1'b0;
`endif

    always_comb begin
        case (sel_s)
            2'd0:    limit = LIMIT_0;
            2'd1:    limit = LIMIT_1;
            2'd2:    limit = LIMIT_2;
            default: limit = LIMIT_3;
        endcase
    end

    assign limit_m1 = limit - 1'b1;

    // Priority: state transition, then select change, then terminal count.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        valid_d = 1'b0;
        sel_d   = sel_s;
        case (state_q)
            ST_STOP: begin
                count_d = '0;
                if (en_s) begin
                    state_d = ST_RUN;
                end else begin
                    valid_d = step_fire;
                end
            end
            default: begin
                if (!en_s) begin
                    state_d = ST_STOP;
                    count_d = '0;
                end else if (sel_s != sel_q) begin
                    count_d = '0;
                end else if ({1'b0, count_q} >= limit_m1) begin
                    // >= keeps the counter bounded if the limit shrinks mid-count
                    count_d = '0;
                    valid_d = 1'b1;
                end else begin
                    count_d = count_q + NB_COUNT'(1);
                end
            end
        endcase
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= ST_STOP;
            count_q   <= '0;
            sel_q     <= '0;
            valid_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            sel_q     <= sel_d;
            valid_q   <= valid_d;
            running_q <= running_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_running = running_q;

endmodule

`default_nettype wire

// File: tb/tb_tick_gen.sv
// ============================================================================
// tb_tick_gen : scoreboard bench for tick_gen with limits 4/8/16/32
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_tick_gen;

    logic       clock;
    logic       i_reset;
    logic       i_enable;
    logic [1:0] i_sel;
    logic       i_step;
    logic       o_valid;
    logic       o_running;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int vq[$];          // expected o_valid pulse cycles
    int rq_cyc[$];      // expected o_running change cycles
    bit rq_val[$];      // value o_running changes to
    logic prev_running = 1'b0;

    tick_gen #(
        .NB_COUNT (32),
        .LIMIT_0  (33'd4),
        .LIMIT_1  (33'd8),
        .LIMIT_2  (33'd16),
        .LIMIT_3  (33'd32)
    ) dut (
        .clock     (clock),
        .i_reset   (i_reset),
        .i_enable  (i_enable),
        .i_sel     (i_sel),
        .i_step    (i_step),
        .o_valid   (o_valid),
        .o_running (o_running)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: compares DUT output events against the expectation queues.
    always @(negedge clock) begin
        int t;
        bit v;
        while (vq.size() > 0 && vq[0] < cyc) begin
            t = vq.pop_front();
            checks++; errors++;
            $display("FAIL tick_missing: no o_valid seen, required pulse at cycle %0d", t);
        end
        if (o_valid) begin
            checks++;
            if (vq.size() > 0 && vq[0] == cyc) begin
                t = vq.pop_front();
            end else begin
                errors++;
                $display("FAIL tick_unexpected: o_valid=1 at cycle %0d, next required pulse %0d",
                         cyc, (vq.size() > 0) ? vq[0] : -1);
            end
        end
        while (rq_cyc.size() > 0 && rq_cyc[0] < cyc) begin
            t = rq_cyc.pop_front();
            v = rq_val.pop_front();
            checks++; errors++;
            $display("FAIL running_missing: o_running stayed %0b, required change to %0b at cycle %0d",
                     o_running, v, t);
        end
        if (o_running !== prev_running) begin
            checks++;
            if (rq_cyc.size() > 0 && rq_cyc[0] == cyc && rq_val[0] == o_running) begin
                t = rq_cyc.pop_front();
                v = rq_val.pop_front();
            end else begin
                errors++;
                $display("FAIL running_unexpected: o_running=%0b at cycle %0d, required change at %0d",
                         o_running, cyc, (rq_cyc.size() > 0) ? rq_cyc[0] : -1);
            end
            prev_running = o_running;
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b, required %0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ticks(input int first, input int period, input int count);
        for (int k = 0; k < count; k++) vq.push_back(first + k * period);
    endtask

    task automatic push_run(input int c, input bit v);
        rq_cyc.push_back(c);
        rq_val.push_back(v);
    endtask

    task automatic press(input int r);
        wait_cyc(r);
        i_step = 1'b1;
        wait_cyc(r + 10);
        i_step = 1'b0;
    endtask

    initial begin
        i_reset  = 1'b0;
        i_enable = 1'b0;
        i_sel    = 2'd0;
        i_step   = 1'b0;

        wait_cyc(1);
        check("reset_valid", o_valid, 1'b0);
        check("reset_running", o_running, 1'b0);
        wait_cyc(2);
        i_reset = 1'b1;

        // Idle with enable low, then run at period 4.
        wait_cyc(52);
        check("idle_valid", o_valid, 1'b0);
        check("idle_running", o_running, 1'b0);
        i_enable = 1'b1;
        push_run(55, 1'b1);
        push_ticks(59, 4, 6);

        // Switch to period 32 exactly where a tick would have fired at 83.
        wait_cyc(80);
        i_sel = 2'd3;

        // Back to period 4 at count 20: clear lands at 106.
        wait_cyc(103);
        i_sel = 2'd0;
        push_ticks(110, 4, 5);

        wait_cyc(125);
        i_enable = 1'b0;
        push_run(128, 1'b0);

`ifdef TICK_GEN_STEP_EN
        push_ticks(144, 20, 3);
`endif
        press(140);
        press(160);
        press(180);

        // Run at period 8; step presses must add nothing.
        wait_cyc(200);
        i_sel    = 2'd1;
        i_enable = 1'b1;
        push_run(203, 1'b1);
        push_ticks(211, 8, 5);
        press(205);
        press(225);

        // Asynchronous reset mid-count.
        wait_cyc(246);
        push_run(246, 1'b0);
        i_reset = 1'b0;
        #1;
        check("midreset_valid", o_valid, 1'b0);
        check("midreset_running", o_running, 1'b0);
        wait_cyc(248);
        i_reset = 1'b1;
        push_run(251, 1'b1);
        push_ticks(259, 8, 2);

        wait_cyc(275);
        while (vq.size() > 0) begin
            checks++; errors++;
            $display("FAIL tick_missing: no o_valid seen, required pulse at cycle %0d", vq.pop_front());
        end
        while (rq_cyc.size() > 0) begin
            checks++; errors++;
            $display("FAIL running_missing: no o_running change seen, required at cycle %0d", rq_cyc.pop_front());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
